// File: rtl/mult32x32_fast_sched.sv
// Operand scheduler for the 32x32 fast multiplier: accepts a/b pairs, launches the
// multiplier, waits out busy under a watchdog and hands back the 64-bit product.
module mult32x32_fast_sched #(
  parameter bit          BYPASS_ZERO    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        start,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        a_msw_is_0,
  output logic        b_msw_is_0,
  input  logic        busy,
  input  logic [63:0] product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_prod,
  output logic        out_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RESULT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_a_msw0;
  logic             r_b_msw0;
  logic [63:0]      r_prod;
  logic             r_err;

  logic w_accept;
  logic w_zero;
  logic w_waiting;
  logic w_done;
  logic w_timeout;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_RESULT) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_zero    = BYPASS_ZERO && ((in_a == 32'd0) || (in_b == 32'd0));
  assign w_waiting = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign w_done    = (r_state == S_WAIT_LO) && !busy;
  // A completing multiply takes priority over the watchdog firing in the same cycle.
  assign w_timeout = w_waiting && (r_cnt >= CNT_LAST) && !w_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = w_zero ? S_RESULT : S_LAUNCH;
      S_LAUNCH:  w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (busy) w_state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!busy) w_state_nxt = S_RESULT;
      S_RESULT: begin
        if (out_ready) w_state_nxt = in_valid ? (w_zero ? S_RESULT : S_LAUNCH) : S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_RESULT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_msw0 <= 1'b1;
      r_b_msw0 <= 1'b1;
      r_prod   <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= in_a;
        r_b      <= in_b;
        r_a_msw0 <= (in_a[31:16] == 16'd0);
        r_b_msw0 <= (in_b[31:16] == 16'd0);
        if (w_zero) begin
          r_prod <= '0;
          r_err  <= 1'b0;
        end
      end
      if (r_state == S_LAUNCH) r_cnt <= '0;
      else if (w_waiting && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
      if (w_done) begin
        r_prod <= product;
        r_err  <= 1'b0;
      end else if (w_timeout) begin
        r_prod <= '0;
        r_err  <= 1'b1;
      end
    end
  end

  assign start      = (r_state == S_LAUNCH);
  assign out_valid  = (r_state == S_RESULT);
  assign a          = r_a;
  assign b          = r_b;
  assign a_msw_is_0 = r_a_msw0;
  assign b_msw_is_0 = r_b_msw0;
  assign out_prod   = r_prod;
  assign out_err    = r_err;

endmodule
